// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: glyph table, special codes and the frame slot payload.
// The display encoder drives the bus from the same table, so both ends always agree.
package seg_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned CODE_W     = 5;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NUM_GLYPHS = 17;

  localparam logic [CODE_W-1:0] CODE_BLANK = 5'd17;
  localparam logic [CODE_W-1:0] CODE_BAD   = 5'd31;

  // Active-high segment bit positions within a 7-bit pattern
  typedef enum int unsigned {
    SEG_A = 0, SEG_B = 1, SEG_C = 2, SEG_D = 3, SEG_E = 4, SEG_F = 5, SEG_G = 6
  } seg_bit_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              dp;
  } slot_t;

  // Active-high glyph for codes 0-16 (hex digits plus '-' for 16)
  function automatic logic [SEG_W-1:0] glyph_pattern(input logic [CODE_W-1:0] code);
    case (code)
      5'd0:    glyph_pattern = 7'h3F;
      5'd1:    glyph_pattern = 7'h06;
      5'd2:    glyph_pattern = 7'h5B;
      5'd3:    glyph_pattern = 7'h4F;
      5'd4:    glyph_pattern = 7'h66;
      5'd5:    glyph_pattern = 7'h6D;
      5'd6:    glyph_pattern = 7'h7D;
      5'd7:    glyph_pattern = 7'h07;
      5'd8:    glyph_pattern = 7'h7F;
      5'd9:    glyph_pattern = 7'h6F;
      5'd10:   glyph_pattern = 7'h77;
      5'd11:   glyph_pattern = 7'h7C;
      5'd12:   glyph_pattern = 7'h39;
      5'd13:   glyph_pattern = 7'h5E;
      5'd14:   glyph_pattern = 7'h79;
      5'd15:   glyph_pattern = 7'h71;
      5'd16:   glyph_pattern = 7'h40;
      default: glyph_pattern = 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg_glyph_lookup.sv
// Reverse glyph lookup: active-high 7-bit segment pattern to display code.
// All-off maps to CODE_BLANK; anything outside the table maps to CODE_BAD.
module seg_glyph_lookup
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0]  pattern,
  output logic [CODE_W-1:0] code_c
);

  always_comb begin
    code_c = CODE_BAD;
    if (pattern == '0) begin
      code_c = CODE_BLANK;
    end
    for (int unsigned i = 0; i < NUM_GLYPHS; i++) begin
      if (pattern == glyph_pattern(CODE_W'(i))) begin
        code_c = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receiver for the multiplexed four-digit 7-segment bus: tracks stable digit windows,
// captures each position into a shadow frame and publishes all four positions together.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned STALE_CYCLES  = 65536
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_DIGITS-1:0] Anodes,
  input  logic [7:0]            Cathodes,
  output logic [CODE_W-1:0]     digit0,
  output logic [CODE_W-1:0]     digit1,
  output logic [CODE_W-1:0]     digit2,
  output logic [CODE_W-1:0]     digit3,
  output logic [NUM_DIGITS-1:0] blank,
  output logic [NUM_DIGITS-1:0] dp,
  output logic                  frame_done,
  output logic                  pattern_err,
  output logic                  multi_err,
  output logic                  stale
);

  localparam int unsigned WIN_W   = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned STALE_W = $clog2(STALE_CYCLES + 1);
  localparam int unsigned SEL_W   = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, TRACK, CAPTURED} state_t;

  logic [NUM_DIGITS-1:0] an_meta, an_sync, an_prev;
  logic [7:0]            ca_meta, ca_sync, ca_prev;
  logic                  multi_prev;

  logic [2:0]       low_count_c;
  logic [SEL_W-1:0] sel_c;
  logic             single_c, multi_c;

  state_t           state, state_next;
  logic [WIN_W-1:0] win_cnt, win_cnt_next;
  logic             capture_c;

  logic [CODE_W-1:0]     code_c;
  slot_t                 shadow [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] seen;
  logic                  commit_c;

  logic [STALE_W-1:0] stale_cnt, stale_cnt_next;

  // Two-flop synchronizers plus one-cycle history for change detection
  always_ff @(posedge clk) begin
    if (reset) begin
      an_meta    <= '1;
      an_sync    <= '1;
      an_prev    <= '1;
      ca_meta    <= '1;
      ca_sync    <= '1;
      ca_prev    <= '1;
      multi_prev <= 1'b0;
    end else begin
      an_meta    <= Anodes;
      an_sync    <= an_meta;
      an_prev    <= an_sync;
      ca_meta    <= Cathodes;
      ca_sync    <= ca_meta;
      ca_prev    <= ca_sync;
      multi_prev <= multi_c;
    end
  end

  always_comb begin
    low_count_c = '0;
    sel_c       = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!an_sync[i]) begin
        low_count_c = low_count_c + 3'd1;
        sel_c       = SEL_W'(i);
      end
    end
    single_c = (low_count_c == 3'd1);
    multi_c  = (low_count_c > 3'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      win_cnt <= '0;
    end else begin
      state   <= state_next;
      win_cnt <= win_cnt_next;
    end
  end

  // Window tracking: any anode change restarts; cathode changes only matter before capture
  always_comb begin
    state_next   = state;
    win_cnt_next = win_cnt;
    capture_c    = 1'b0;
    unique case (state)
      TRACK: begin
        if ((an_sync == an_prev) && (ca_sync == ca_prev)) begin
          win_cnt_next = win_cnt + WIN_W'(1);
          if (win_cnt_next == WIN_W'(STABLE_CYCLES)) begin
            capture_c  = 1'b1;
            state_next = CAPTURED;
          end
        end else if (single_c) begin
          win_cnt_next = WIN_W'(1);
        end else begin
          state_next = IDLE;
        end
      end
      CAPTURED: begin
        if (an_sync != an_prev) begin
          if (single_c) begin
            state_next   = TRACK;
            win_cnt_next = WIN_W'(1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        if (single_c) begin
          state_next   = TRACK;
          win_cnt_next = WIN_W'(1);
        end
      end
    endcase
  end

  seg_glyph_lookup u_lookup (
    .pattern (~ca_sync[SEG_W-1:0]),
    .code_c  (code_c)
  );

  assign commit_c = &seen;

  // Shadow capture and frame commit
  always_ff @(posedge clk) begin
    if (reset) begin
      seen        <= '0;
      frame_done  <= 1'b0;
      pattern_err <= 1'b0;
      multi_err   <= 1'b0;
      digit0      <= CODE_BLANK;
      digit1      <= CODE_BLANK;
      digit2      <= CODE_BLANK;
      digit3      <= CODE_BLANK;
      blank       <= '1;
      dp          <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '{code: CODE_BLANK, dp: 1'b0};
      end
    end else begin
      frame_done  <= commit_c;
      pattern_err <= capture_c && (code_c == CODE_BAD);
      multi_err   <= multi_c && !multi_prev;
      seen        <= (commit_c ? '0 : seen) |
                     (capture_c ? (NUM_DIGITS'(1) << sel_c) : '0);
      if (capture_c) begin
        shadow[sel_c] <= '{code: code_c, dp: ~ca_sync[7]};
      end
      if (commit_c) begin
        digit0 <= shadow[0].code;
        digit1 <= shadow[1].code;
        digit2 <= shadow[2].code;
        digit3 <= shadow[3].code;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          blank[i] <= (shadow[i].code == CODE_BLANK);
          dp[i]    <= shadow[i].dp;
        end
      end
    end
  end

  // Stale watchdog: restarts on each commit, saturates when frames stop arriving
  always_comb begin
    stale_cnt_next = stale_cnt;
    if (commit_c) begin
      stale_cnt_next = '0;
    end else if (stale_cnt != STALE_W'(STALE_CYCLES)) begin
      stale_cnt_next = stale_cnt + STALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stale_cnt <= STALE_W'(STALE_CYCLES);
      stale     <= 1'b1;
    end else begin
      stale_cnt <= stale_cnt_next;
      stale     <= (stale_cnt_next == STALE_W'(STALE_CYCLES));
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: window-level reference model feeds a frame scoreboard,
// a forked monitor checks each published frame; directed cases plus random scan traffic.
module tb_seg_scan_decoder;

  localparam int unsigned STABLE = 4;
  localparam int unsigned STALE  = 65536;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Anodes;
  logic [7:0] Cathodes;
  logic [4:0] digit0, digit1, digit2, digit3;
  logic [3:0] blank, dp;
  logic       frame_done, pattern_err, multi_err, stale;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(STABLE), .STALE_CYCLES(STALE)) dut (
    .clk(clk), .reset(reset), .Anodes(Anodes), .Cathodes(Cathodes),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .blank(blank), .dp(dp), .frame_done(frame_done), .pattern_err(pattern_err),
    .multi_err(multi_err), .stale(stale)
  );

  typedef struct packed {
    logic [3:0][4:0] code;
    logic [3:0]      blank;
    logic [3:0]      dp;
  } frame_t;

  frame_t     exp_q[$];
  logic [6:0] glyph_tb [17];
  int checks = 0, errors = 0;
  int exp_perr = 0, exp_merr = 0, got_perr = 0, got_merr = 0;

  // Reference model state, one step per driven window
  logic [3:0] cur_a;
  logic [7:0] cur_c;
  int         run;
  bit         captured;
  bit   [3:0] m_seen;
  int         m_code [4];
  bit         m_dp [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  function automatic int count_low(input logic [3:0] a);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) n++;
    return n;
  endfunction

  function automatic int model_lookup(input logic [7:0] c);
    logic [6:0] p = ~c[6:0];
    if (p == 7'h00) return 17;
    for (int i = 0; i < 17; i++) if (glyph_tb[i] == p) return i;
    return 31;
  endfunction

  function automatic logic [7:0] cath(input int code, input logic dpo);
    return {~dpo, ~glyph_tb[code]};
  endfunction

  function automatic logic [3:0] sel(input int pos);
    return ~(4'b0001 << pos);
  endfunction

  task automatic model_reset();
    cur_a = 4'hF; cur_c = 8'hFF; run = 0; captured = 0; m_seen = '0;
  endtask

  // Apply one constant bus state for len cycles and advance the model
  task automatic window(input logic [3:0] a, input logic [7:0] c, input int len);
    int   pos;
    frame_t f;
    if (a != cur_a) begin
      if (count_low(a) > 1 && count_low(cur_a) <= 1) exp_merr++;
      cur_a = a; cur_c = c; run = 0; captured = 0;
    end else if (c != cur_c) begin
      cur_c = c; run = 0;
    end
    run += len;
    if (count_low(a) == 1 && !captured && run >= int'(STABLE)) begin
      captured = 1;
      pos = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) pos = i;
      m_code[pos] = model_lookup(c);
      m_dp[pos]   = !c[7];
      m_seen[pos] = 1'b1;
      if (m_code[pos] == 31) exp_perr++;
      if (&m_seen) begin
        for (int i = 0; i < 4; i++) begin
          f.code[i]  = 5'(m_code[i]);
          f.blank[i] = (m_code[i] == 17);
          f.dp[i]    = m_dp[i];
        end
        exp_q.push_back(f);
        m_seen = '0;
      end
    end
    Anodes = a;
    Cathodes = c;
    repeat (len) @(negedge clk);
  endtask

  task automatic scan4(input logic [7:0] c3, c2, c1, c0, input int len);
    window(sel(3), c3, len);
    window(sel(2), c2, len);
    window(sel(1), c1, len);
    window(sel(0), c0, len);
  endtask

  task automatic monitor();
    frame_t e;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("digit0", 32'(digit0), 32'(e.code[0]));
          check("digit1", 32'(digit1), 32'(e.code[1]));
          check("digit2", 32'(digit2), 32'(e.code[2]));
          check("digit3", 32'(digit3), 32'(e.code[3]));
          check("blank",  32'(blank),  32'(e.blank));
          check("dp",     32'(dp),     32'(e.dp));
        end
      end
      if (pattern_err) got_perr++;
      if (multi_err) got_merr++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_digit0"}, 32'(digit0), 32'd17);
    check({tag, "_digit1"}, 32'(digit1), 32'd17);
    check({tag, "_digit2"}, 32'(digit2), 32'd17);
    check({tag, "_digit3"}, 32'(digit3), 32'd17);
    check({tag, "_blank"},  32'(blank),  32'hF);
    check({tag, "_dp"},     32'(dp),     32'h0);
    check({tag, "_stale"},  32'(stale),  32'd1);
  endtask

  initial begin
    int k;
    logic [3:0] a;
    logic [7:0] c;
    glyph_tb = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h40};
    reset = 1'b1; Anodes = 4'hF; Cathodes = 8'hFF;
    model_reset();
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    check("reset_frame_done", 32'(frame_done), 32'd0);

    // One frame, then measure the stale timeout from its frame_done
    window(sel(3), cath(5, 0), 16);
    window(sel(2), cath(6, 1), 16);
    window(sel(1), cath(8, 0), 16);
    window(sel(0), cath(9, 0), int'(STABLE));
    window(4'hF, 8'hFF, 0);
    k = 0;
    while (!frame_done && k < 40) begin @(negedge clk); k++; end
    check("stale_frame_seen", 32'(frame_done), 32'd1);
    check("stale_after_frame", 32'(stale), 32'd0);
    repeat (STALE - 1) @(negedge clk);
    check("stale_before_limit", 32'(stale), 32'd0);
    @(negedge clk);
    check("stale_at_limit", 32'(stale), 32'd1);

    // "1234" across digit3..0, two rotations
    scan4(cath(1, 0), cath(2, 0), cath(3, 0), cath(4, 0), 16);
    scan4(cath(1, 0), cath(2, 0), cath(3, 0), cath(4, 0), 16);
    // Three blank positions with digit0 showing 7
    scan4(8'hFF, 8'hFF, 8'hFF, cath(7, 0), 16);
    // Short digit1 window defers the frame until a full-length one arrives
    window(sel(3), cath(10, 0), 16);
    window(sel(2), cath(11, 1), 16);
    window(sel(1), cath(12, 0), int'(STABLE) - 1);
    window(sel(0), cath(13, 0), 16);
    window(sel(3), cath(14, 0), 16);
    window(sel(2), cath(15, 0), 16);
    window(sel(1), cath(16, 1), 16);
    // Two anodes low inside a scan
    window(sel(3), cath(0, 0), 16);
    window(4'b1100, cath(8, 0), 10);
    window(sel(2), cath(2, 0), 16);
    window(sel(1), cath(3, 0), 16);
    window(sel(0), cath(4, 0), 16);
    // Unrecognized pattern on digit2
    scan4(cath(9, 0), ~{1'b0, 7'h49}, cath(1, 1), cath(0, 0), 16);
    window(4'hF, 8'hFF, 10);

    // Reset mid-frame discards the partial capture
    window(sel(3), cath(6, 0), 16);
    window(sel(2), cath(6, 0), 16);
    window(sel(1), cath(6, 0), 2);
    reset = 1'b1; Anodes = 4'hF; Cathodes = 8'hFF;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    window(sel(0), cath(3, 0), 16);
    window(sel(1), cath(3, 0), 16);
    window(4'hF, 8'hFF, 10);

    // Random scan traffic
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 9));
      if (k == 0) begin
        a = 4'hF;
      end else if (k == 1) begin
        do a = 4'($urandom_range(0, 15)); while (count_low(a) < 2);
      end else begin
        a = sel(int'($urandom_range(0, 3)));
      end
      k = int'($urandom_range(0, 9));
      if (k == 0) c = {1'($urandom_range(0, 1)), 7'h7F};
      else if (k == 1) c = 8'($urandom_range(0, 255));
      else c = cath(int'($urandom_range(0, 16)), 1'($urandom_range(0, 1)));
      window(a, c, int'($urandom_range(1, 12)));
    end

    window(4'hF, 8'hFF, 0);
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    check("frames_drained", 32'(exp_q.size()), 32'd0);
    check("pattern_err_count", 32'(got_perr), 32'(exp_perr));
    check("multi_err_count", 32'(got_merr), 32'(exp_merr));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
